// File: rtl/primitive_assembly.sv
// Primitive assembly: groups an incoming vertex stream into triangles for
// list, strip and fan topologies, with a registered one-deep output stage.
module primitive_assembly #(
  parameter int ATTR_WIDTH       = 32,
  parameter int ATTRS_PER_VERTEX = 8,
  localparam int VW              = ATTR_WIDTH * ATTRS_PER_VERTEX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    i_prim_mode,
  input  logic          i_restart,
  input  logic          i_vertex_valid,
  input  logic [VW-1:0] i_vertex_data,
  output logic          o_vertex_ready,
  output logic          o_tri_valid,
  output logic [VW-1:0] o_tri_v0,
  output logic [VW-1:0] o_tri_v1,
  output logic [VW-1:0] o_tri_v2,
  input  logic          i_tri_ready,
  output logic [31:0]   o_tri_count
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ONE    = 2'd1,
    PRIMED = 2'd2
  } state_t;

  state_t        state;
  logic [VW-1:0] slot_a;
  logic [VW-1:0] slot_b;
  logic          parity;

  logic          accept;
  logic          tri_done;
  logic          is_strip;
  logic          is_fan;

  // A vertex can enter whenever the output register is free or draining this
  // cycle; a restart pulse blocks intake so the discarded state is not mixed in.
  assign o_vertex_ready = (!o_tri_valid || i_tri_ready) && !i_restart;
  assign accept         = i_vertex_valid && o_vertex_ready;
  assign tri_done       = o_tri_valid && i_tri_ready;

  // Mode 11 is reserved and falls through to list behaviour.
  assign is_strip = (i_prim_mode == 2'b01);
  assign is_fan   = (i_prim_mode == 2'b10);

  // Assembly FSM, held slots and registered triangle output in one process so
  // a drain and a new emission on the same edge leave o_tri_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      slot_a      <= '0;
      slot_b      <= '0;
      parity      <= 1'b0;
      o_tri_valid <= 1'b0;
      o_tri_v0    <= '0;
      o_tri_v1    <= '0;
      o_tri_v2    <= '0;
      o_tri_count <= 32'd0;
    end else begin
      if (tri_done) begin
        o_tri_valid <= 1'b0;
        o_tri_count <= o_tri_count + 32'd1;
      end
      if (i_restart) begin
        state  <= EMPTY;
        parity <= 1'b0;
      end else if (accept) begin
        case (state)
          EMPTY: begin
            slot_a <= i_vertex_data;
            state  <= ONE;
          end
          ONE: begin
            slot_b <= i_vertex_data;
            state  <= PRIMED;
          end
          PRIMED: begin
            o_tri_valid <= 1'b1;
            o_tri_v2    <= i_vertex_data;
            if (is_strip) begin
              o_tri_v0 <= parity ? slot_b : slot_a;
              o_tri_v1 <= parity ? slot_a : slot_b;
              slot_a   <= slot_b;
              slot_b   <= i_vertex_data;
              parity   <= ~parity;
            end else if (is_fan) begin
              o_tri_v0 <= slot_a;
              o_tri_v1 <= slot_b;
              slot_b   <= i_vertex_data;
            end else begin
              o_tri_v0 <= slot_a;
              o_tri_v1 <= slot_b;
              state    <= EMPTY;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: doc/primitive_assembly.md
PRIMITIVE_ASSEMBLY -- requirements
Module: primitive_assembly

Interface
REQ-001 The module SHALL have parameter ATTR_WIDTH, default 32, meaning the width of one vertex attribute.
REQ-002 The module SHALL have parameter ATTRS_PER_VERTEX, default 8, meaning attributes per vertex; VW = ATTR_WIDTH*ATTRS_PER_VERTEX.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port i_prim_mode, input, 2 bits: 00 triangle list, 01 triangle strip, 10 triangle fan, 11 reserved and treated as list.
REQ-006 The module SHALL have port i_restart, input, 1 bit: one-cycle pulse that discards partial assembly (new draw or primitive restart).
REQ-007 The module SHALL have port i_vertex_valid, input, 1 bit: a vertex is offered on i_vertex_data.
REQ-008 The module SHALL have port i_vertex_data, input, VW bits: vertex attributes as delivered by the vertex fetch stage.
REQ-009 The module SHALL have port o_vertex_ready, output, 1 bit: the vertex is accepted when valid and ready are both high on a rising edge.
REQ-010 The module SHALL have port o_tri_valid, output, 1 bit: a triangle is presented on o_tri_v0/v1/v2.
REQ-011 The module SHALL have ports o_tri_v0, o_tri_v1 and o_tri_v2, outputs, VW bits each: triangle vertices in emitted winding order.
REQ-012 The module SHALL have port i_tri_ready, input, 1 bit: the downstream rasteriser setup accepts the triangle.
REQ-013 The module SHALL have port o_tri_count, output, 32 bits: triangles accepted downstream since reset, wrapping from 0xFFFFFFFF to 0.

Function
REQ-014 Assembly state SHALL be a 3-state machine (EMPTY, ONE, PRIMED) plus held slots A and B (VW bits each) and a strip parity bit.
REQ-015 o_vertex_ready SHALL equal (!o_tri_valid || i_tri_ready) && !i_restart, so acceptance proceeds at one vertex per cycle while output drains.
REQ-016 On acceptance in EMPTY: A <= vertex, go to ONE; in ONE: B <= vertex, go to PRIMED; no triangle is emitted.
REQ-017 List mode, acceptance in PRIMED: emit (A, B, vertex) and go to EMPTY.
REQ-018 Strip mode, acceptance in PRIMED: emit (A, B, vertex) when parity=0 or (B, A, vertex) when parity=1; then A <= B, B <= vertex, toggle parity, and stay in PRIMED.
REQ-019 Fan mode, acceptance in PRIMED: emit (A, B, vertex); then B <= vertex, keep A, and stay in PRIMED.
REQ-020 Emission SHALL register the triangle: o_tri_valid rises the cycle after the completing acceptance, giving 1-cycle latency.
REQ-021 o_tri_valid and o_tri_v0..v2 SHALL hold stable until o_tri_valid && i_tri_ready on a rising edge.
REQ-022 If a handshake completes and a new triangle is emitted on the same edge, o_tri_valid SHALL stay high with the new data, with no bubble.
REQ-023 o_tri_count SHALL increment by 1 on each downstream handshake.
REQ-024 i_restart SHALL set EMPTY and parity=0 on the next edge, blocking any vertex offered in the same cycle (o_vertex_ready low).
REQ-025 i_restart SHALL NOT alter a pending output triangle or o_tri_count.
REQ-026 i_prim_mode SHALL be sampled at each acceptance; changing it without i_restart mid-primitive is a protocol error with unspecified triangle content, and the state machine must stay legal.
REQ-027 No degenerate-triangle culling SHALL be performed; every completed triangle is emitted.

Reset
REQ-028 While rst_n=0: state EMPTY, parity 0, o_tri_valid 0, o_tri_v0..v2 0, o_tri_count 0, slots A/B 0.
REQ-029 Reset asserted mid-primitive or with a triangle pending SHALL discard both, and o_vertex_ready SHALL be 1 after release.

Verification
REQ-030 List: mode 00, vertices 1..6 back-to-back, i_tri_ready=1 -> triangles (1,2,3), (4,5,6); o_tri_count=2.
REQ-031 Strip: mode 01, vertices 1..5 -> (1,2,3), (3,2,4), (3,4,5), one per cycle after priming; o_tri_count=3.
REQ-032 Fan: mode 10, vertices 1..5 -> (1,2,3), (1,3,4), (1,4,5).
REQ-033 Backpressure: i_tri_ready=0 for 5 cycles with a triangle pending -> o_vertex_ready=0, outputs stable; on release, the next triangle follows without a bubble.
REQ-034 Restart: strip with vertices 1,2, then i_restart while vertex 3 is offered -> 3 not accepted; then 3,4,5 -> (3,4,5) with parity 0.
REQ-035 Reset: rst_n low with a triangle pending and state PRIMED -> all outputs 0; vertices 7,8,9 after release -> (7,8,9) in list mode.
